// File: rtl/ctrl_fsm_if.sv
// Control/datapath boundary of the multi-cycle core: status flags into the
// sequencer, strobes, selects and status out of it.
interface ctrl_fsm_if #(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
);
    logic [OPW-1:0]   opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             ir_we;
    logic             mem_rd;
    logic             mem_we;
    logic             addr_sel;
    logic [2:0]       alu_op;
    logic             alu_src;
    logic             rf_we;
    logic             wb_sel;
    logic             halted;
    logic             bus_err;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_we, pc_src, ir_we, mem_rd, mem_we, addr_sel, alu_op,
               alu_src, rf_we, wb_sel, halted, bus_err, illegal, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_we, pc_src, ir_we, mem_rd, mem_we, addr_sel, alu_op,
               alu_src, rf_we, wb_sel, halted, bus_err, illegal, retired
    );
endinterface

// File: rtl/ctrl_fsm.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB], with memory
// wait-states, access timeout, sticky error flags and a retired-instruction count.
module ctrl_fsm #(
    parameter int OPW     = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    ctrl_fsm_if.master bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
    localparam logic [OPW-1:0] OP_LD   = OPW'(6);
    localparam logic [OPW-1:0] OP_ST   = OPW'(7);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(8);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(9);
    localparam logic [OPW-1:0] OP_HLT  = OPW'(15);
    localparam logic [OPW-1:0] OP_UNDEF_LO = OPW'(10);
    localparam logic [OPW-1:0] OP_UNDEF_HI = OPW'(14);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              bus_err_q, bus_err_d;
    logic              illegal_q, illegal_d;
    logic              retire;
    logic              wait_expired;

    assign wait_expired = (wait_q == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RST;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_d       = wait_q;
        bus_err_d    = bus_err_q;
        illegal_d    = illegal_q;
        retire       = 1'b0;
        bus.pc_we    = 1'b0;
        bus.pc_src   = 2'd0;
        bus.ir_we    = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        bus.alu_op   = 3'd0;
        bus.alu_src  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.halted   = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;

            S_FETCH: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = S_DECODE;
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_DECODE: begin
                op_d = bus.opcode;
                if (bus.opcode >= OP_UNDEF_LO && bus.opcode <= OP_UNDEF_HI)
                    illegal_d = 1'b1;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                case (op_q)
                    OP_ADD: state_d = S_WB;
                    OP_SUB: begin bus.alu_op = 3'd1; state_d = S_WB; end
                    OP_AND: begin bus.alu_op = 3'd2; state_d = S_WB; end
                    OP_OR:  begin bus.alu_op = 3'd3; state_d = S_WB; end
                    OP_ADDI: begin
                        bus.alu_src = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        // ALU forms base + offset for the MEM-phase address
                        bus.alu_src = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_BEQ: begin
                        bus.alu_op = 3'd1;
                        if (bus.zero) begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = 2'd1;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        bus.pc_we  = 1'b1;
                        bus.pc_src = 2'd2;
                        retire     = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OP_HLT: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                bus.addr_sel = 1'b1;
                bus.mem_rd   = (op_q == OP_LD);
                bus.mem_we   = (op_q == OP_ST);
                if (bus.mem_ready) begin
                    if (op_q == OP_LD) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_WB: begin
                bus.rf_we  = 1'b1;
                bus.wb_sel = (op_q == OP_LD);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_HALT: bus.halted = 1'b1;

            default: state_d = S_RST;
        endcase

        // Every fresh memory phase starts its timeout window at zero
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
            wait_d = '0;

        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    assign bus.bus_err = bus_err_q;
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_ctrl_fsm.sv
// Randomized bench for ctrl_fsm: an instruction-level script predicts every
// cycle's control word, counter and sticky flags.
module tb_ctrl_fsm;
    localparam int OPW = 4;
    localparam int TO  = 15;
    localparam int CW  = 4;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       mem_rd;
        logic       mem_we;
        logic       addr_sel;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       rf_we;
        logic       wb_sel;
        logic       halted;
    } outs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_ret;
    logic exp_be, exp_il, halted_m;

    ctrl_fsm_if #(.OPW(OPW), .CNT_W(CW)) bus ();

    ctrl_fsm #(.OPW(OPW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input outs_t e, input string tag);
        outs_t o;
        o = {bus.pc_we, bus.pc_src, bus.ir_we, bus.mem_rd, bus.mem_we, bus.addr_sel,
             bus.alu_op, bus.alu_src, bus.rf_we, bus.wb_sel, bus.halted};
        chk(tag, 32'(o), 32'(e));
        chk({tag, "_retired"}, 32'(bus.retired), 32'(exp_ret % (1 << CW)));
        chk({tag, "_flags"}, 32'({bus.bus_err, bus.illegal}), 32'({exp_be, exp_il}));
    endtask

    // One clock: drive at the falling edge, check mid-low-phase
    task automatic cyc(input logic rdy, input logic z, input logic [3:0] opc,
                       input outs_t e, input string tag);
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.opcode    = opc;
        #1;
        chk_all(e, tag);
    endtask

    task automatic do_reset();
        outs_t e;
        e = '0;
        @(negedge clk);
        reset = 1'b1;
        exp_ret = 0; exp_be = 1'b0; exp_il = 1'b0; halted_m = 1'b0;
        #1 chk_all(e, "rst_async");
        @(negedge clk);
        #1 chk_all(e, "rst_hold");
        @(negedge clk);
        reset = 1'b0;
        #1 chk_all(e, "rst_state");
    endtask

    // Memory phase with wait-states; returns 1 on success, 0 on timeout
    task automatic mem_phase(input int waits, input outs_t base, input string tag,
                             output logic ok);
        outs_t e;
        logic  done;
        done = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i <= TO && !done; i++) begin
            logic rdy;
            rdy = (i == waits);
            e = base;
            if (rdy && tag == "fetch") begin
                e.ir_we = 1'b1;
                e.pc_we = 1'b1;
            end
            cyc(rdy, 1'($urandom), 4'($urandom), e, tag);
            if (rdy) begin
                done = 1'b1;
                ok   = 1'b1;
            end else if (i == TO) begin
                done = 1'b1;
                exp_be   = 1'b1;
                halted_m = 1'b1;
            end
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
        outs_t e;
        logic  ok;
        logic  to_mem, to_wb;
        e = '0;
        e.mem_rd = 1'b1;
        mem_phase(fw, e, "fetch", ok);
        if (!ok) return;

        e = '0;
        cyc(1'($urandom), 1'($urandom), op, e, "decode");
        if (op >= 4'hA && op <= 4'hE) exp_il = 1'b1;

        e = '0;
        to_mem = 1'b0;
        to_wb  = 1'b0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4: begin e.alu_op = 3'(op - 4'h1); to_wb = 1'b1; end
            4'h5: begin e.alu_src = 1'b1; to_wb = 1'b1; end
            4'h6, 4'h7: begin e.alu_src = 1'b1; to_mem = 1'b1; end
            4'h8: begin
                e.alu_op = 3'd1;
                if (z) begin e.pc_we = 1'b1; e.pc_src = 2'd1; end
            end
            4'h9: begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
            default: ;
        endcase
        cyc(1'($urandom), z, 4'($urandom), e, "exec");
        if (!to_mem && !to_wb) begin
            exp_ret++;
            if (op == 4'hF) halted_m = 1'b1;
            return;
        end

        if (to_mem) begin
            e = '0;
            e.addr_sel = 1'b1;
            e.mem_rd   = (op == 4'h6);
            e.mem_we   = (op == 4'h7);
            mem_phase(mw, e, "mem", ok);
            if (!ok) return;
            if (op == 4'h7) begin
                exp_ret++;
                return;
            end
        end

        e = '0;
        e.rf_we  = 1'b1;
        e.wb_sel = (op == 4'h6);
        cyc(1'($urandom), 1'($urandom), 4'($urandom), e, "wb");
        exp_ret++;
    endtask

    task automatic halt_cycles(input int n);
        outs_t e;
        e = '0;
        e.halted = 1'b1;
        for (int i = 0; i < n; i++)
            cyc(1'(i), 1'($urandom), 4'($urandom), e, "halt");
    endtask

    function automatic int pick_waits();
        int r;
        r = int'($urandom_range(0, 39));
        if (r < 26) return 0;
        if (r < 37) return int'($urandom_range(1, 3));
        if (r == 37) return 15;
        return 16;
    endfunction

    initial begin
        outs_t e;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        bus.opcode    = '0;
        exp_ret = 0; exp_be = 1'b0; exp_il = 1'b0; halted_m = 1'b0;

        do_reset();
        run_instr(4'h1, 0, 0, 1'b0);          // ADD, no waits
        run_instr(4'h6, 2, 2, 1'b0);          // LD, 2 waits each phase
        run_instr(4'h8, 0, 0, 1'b1);          // BEQ taken
        run_instr(4'h8, 0, 0, 1'b0);          // BEQ not taken
        run_instr(4'h7, 1, 3, 1'b0);          // ST
        run_instr(4'h9, 0, 0, 1'b0);          // JMP
        run_instr(4'h1, 15, 0, 1'b0);         // ready on the last allowed cycle
        run_instr(4'hB, 0, 0, 1'b0);          // undefined -> NOP + illegal
        run_instr(4'h0, 16, 0, 1'b0);         // fetch timeout
        halt_cycles(4);

        do_reset();
        run_instr(4'h6, 0, 16, 1'b0);         // MEM timeout
        halt_cycles(2);

        do_reset();
        run_instr(4'hF, 0, 0, 1'b0);          // HLT
        halt_cycles(6);

        // Reset in the middle of a fetch wait must drop mem_rd immediately
        do_reset();
        e = '0;
        e.mem_rd = 1'b1;
        cyc(1'b0, 1'b0, 4'h0, e, "fetch_wait");
        cyc(1'b0, 1'b0, 4'h0, e, "fetch_wait");
        do_reset();

        for (int i = 0; i < 17; i++) run_instr(4'h0, 0, 0, 1'b0);
        @(posedge clk);
        #1 chk("nop17_retired", 32'(bus.retired), 32'd1);

        for (int n = 0; n < 160; n++) begin
            logic [3:0] op;
            op = 4'($urandom);
            if (op == 4'hF && ($urandom_range(0, 3) != 0)) op = 4'h5;
            run_instr(op, pick_waits(), pick_waits(), 1'($urandom));
            if (halted_m) begin
                halt_cycles(2);
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
